multi_pulser: RTL and testbench



---
 rtl/multi_pulser.sv | 127 ++++++++++++
 tb/tb_multi_pulser.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/multi_pulser.sv
// Multi-channel pulse generator: a shared period counter drives NCH channels with per-channel delay/width.
// Optional macro RETRIG_EN: a TRIG while running restarts the run instead of being ignored.
module multi_pulser #(
  parameter int CNT_W   = 32,
  parameter int NCH     = 2,
  parameter int BURST_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 TRIG,
  input  logic [CNT_W-1:0]     PERIOD,
  input  logic [NCH*CNT_W-1:0] DELAY,
  input  logic [NCH*CNT_W-1:0] WIDTH,
  input  logic [BURST_W-1:0]   BURST,
  output logic [NCH-1:0]       PULSE,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 LED
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     p;
  logic [BURST_W-1:0]   b;
  logic [CNT_W-1:0]     period_s;
  logic [NCH*CNT_W-1:0] delay_s;
  logic [NCH*CNT_W-1:0] width_s;
  logic [BURST_W-1:0]   burst_s;
  logic [NCH-1:0]       cond;
  logic                 start;
  logic                 last;
  logic                 burst_end;

  // A one-cycle period would leave no room for a low phase, so the period floors at 2.
  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] v);
    return (v < CNT_W'(2)) ? CNT_W'(2) : v;
  endfunction

  // Window end is formed one bit wider so delay+width never wraps back into range.
  function automatic logic chan_hit(input logic [CNT_W-1:0] pos,
                                    input logic [CNT_W-1:0] d,
                                    input logic [CNT_W-1:0] w,
                                    input logic [CNT_W-1:0] per);
    logic [CNT_W:0] stop;
    stop = {1'b0, d} + {1'b0, w};
    return (d <= pos) && ({1'b0, pos} < stop) && (pos < per);
  endfunction

  always_comb begin
    cond = '0;
    for (int k = 0; k < NCH; k++)
      cond[k] = chan_hit(p, delay_s[k*CNT_W +: CNT_W], width_s[k*CNT_W +: CNT_W], period_s);
  end

`ifdef RETRIG_EN
  assign start = EN && TRIG;
`else
  assign start = EN && TRIG && (state == IDLE);
`endif

  assign last      = (p == period_s - CNT_W'(1));
  assign burst_end = last && (burst_s != '0) && (b == burst_s - BURST_W'(1));

  // Run configuration is captured once per (re)start so later input changes cannot disturb a run.
  always_ff @(posedge CLK) begin
    if (start) begin
      period_s <= clamp_period(PERIOD);
      delay_s  <= DELAY;
      width_s  <= WIDTH;
      burst_s  <= BURST;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      p     <= '0;
      b     <= '0;
      PULSE <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      LED   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          PULSE <= '0;
          if (start) begin
            state <= RUN;
            p     <= '0;
            b     <= '0;
            BUSY  <= 1'b1;
          end
        end
        RUN: begin
          if (!EN) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            PULSE <= '0;
          end else if (start) begin
            p     <= '0;
            b     <= '0;
            PULSE <= '0;
          end else begin
            PULSE <= cond;
            if (last) begin
              p   <= '0;
              b   <= b + BURST_W'(1);
              LED <= ~LED;
              if (burst_end) begin
                state <= IDLE;
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
              end
            end else begin
              p <= p + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_pulser.sv
// Directed bench for multi_pulser: burst, clamp, out-of-range, continuous/abort, reset and retrigger runs.
module tb_multi_pulser;
  localparam int CNT_W   = 32;
  localparam int NCH     = 2;
  localparam int BURST_W = 16;
`ifdef RETRIG_EN
  localparam int DK = 35;
`else
  localparam int DK = 20;
`endif

  logic                 CLK = 1'b0;
  logic                 RST, EN, TRIG;
  logic [CNT_W-1:0]     PERIOD;
  logic [NCH*CNT_W-1:0] DELAY, WIDTH;
  logic [BURST_W-1:0]   BURST;
  logic [NCH-1:0]       PULSE;
  logic                 BUSY, DONE, LED;

  int vectors = 0;
  int miscompares = 0;

  multi_pulser #(.CNT_W(CNT_W), .NCH(NCH), .BURST_W(BURST_W)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .TRIG(TRIG), .PERIOD(PERIOD), .DELAY(DELAY),
    .WIDTH(WIDTH), .BURST(BURST), .PULSE(PULSE), .BUSY(BUSY), .DONE(DONE), .LED(LED)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [31:0] per, input logic [31:0] d0, input logic [31:0] w0,
                     input logic [31:0] d1, input logic [31:0] w1, input logic [15:0] bur);
    PERIOD = per;
    DELAY  = {d1, d0};
    WIDTH  = {w1, w0};
    BURST  = bur;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; TRIG = 1'b0;
    cfg(0, 0, 0, 0, 0, 0);
    cyc(2);
    chk("reset", {PULSE, BUSY, DONE, LED}, 5'b00000);
    RST = 1'b0;

    // Basic burst; inputs scrambled after the trigger must not matter.
    EN = 1'b1;
    cfg(10, 2, 3, 0, 10, 3);
    TRIG = 1'b1; cyc(1); TRIG = 1'b0;
    cfg(3, 0, 1, 1, 1, 1);
    chk("basic E0", {PULSE, BUSY, DONE, LED}, 5'b00100);
    for (int k = 1; k <= 32; k++) begin
      int pb;
      logic p0, p1, bz, dn, ld;
      cyc(1);
      pb = (k - 1) % 10;
      p0 = (k <= 30) && (pb >= 2) && (pb <= 4);
      p1 = (k <= 30);
      bz = (k < 30);
      dn = (k == 30);
      ld = ((k / 10) % 2) == 1;
      chk($sformatf("basic E%0d", k), {PULSE, BUSY, DONE, LED}, {p1, p0, bz, dn, ld});
    end

    // Period 1 clamps to 2; width truncated at the period end.
    cfg(1, 1, 5, 5, 0, 2);
    TRIG = 1'b1; cyc(1); TRIG = 1'b0;
    chk("clamp E0", {PULSE, BUSY, DONE, LED}, 5'b00101);
    for (int k = 1; k <= 5; k++) begin
      logic p0, bz, dn, ld;
      cyc(1);
      p0 = (k <= 4) && (((k - 1) % 2) == 1);
      bz = (k < 4);
      dn = (k == 4);
      ld = 1'b1 ^ (k >= 2) ^ (k >= 4);
      chk($sformatf("clamp E%0d", k), {PULSE, BUSY, DONE, LED}, {1'b0, p0, bz, dn, ld});
    end

    // Zero width and delay == period keep both channels low.
    cfg(8, 0, 0, 8, 4, 1);
    TRIG = 1'b1; cyc(1); TRIG = 1'b0;
    chk("zero E0", {PULSE, BUSY, DONE, LED}, 5'b00101);
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk($sformatf("zero E%0d", k), {PULSE, BUSY, DONE, LED},
          {2'b00, (k < 8), (k == 8), (k != 8)});
    end

    // Restart on the edge right after DONE, continuous mode, then abort.
    cfg(5, 1, 2, 4, 9, 0);
    TRIG = 1'b1; cyc(1); TRIG = 1'b0;
    chk("cont E0", {PULSE, BUSY, DONE, LED}, 5'b00100);
    for (int k = 1; k <= 16; k++) begin
      int pb;
      logic p0, p1, ld;
      cyc(1);
      pb = (k - 1) % 5;
      p0 = (pb >= 1) && (pb <= 2);
      p1 = (pb == 4);
      ld = ((k / 5) % 2) == 1;
      chk($sformatf("cont E%0d", k), {PULSE, BUSY, DONE, LED}, {p1, p0, 1'b1, 1'b0, ld});
    end
    EN = 1'b0; cyc(1);
    chk("abort E17", {PULSE, BUSY, DONE, LED}, 5'b00001);
    TRIG = 1'b1; cyc(2); TRIG = 1'b0;
    chk("trig with EN low", {PULSE, BUSY, DONE, LED}, 5'b00001);

    // Synchronous reset mid-run, then a fresh run.
    EN = 1'b1;
    cfg(10, 0, 10, 3, 2, 0);
    TRIG = 1'b1; cyc(1); TRIG = 1'b0;
    cyc(6);
    chk("prerst E6", {PULSE, BUSY, DONE, LED}, 5'b01101);
    RST = 1'b1; TRIG = 1'b1; cyc(1);
    chk("rst E7", {PULSE, BUSY, DONE, LED}, 5'b00000);
    cyc(1);
    chk("rst E8", {PULSE, BUSY, DONE, LED}, 5'b00000);
    RST = 1'b0; cyc(1); TRIG = 1'b0;
    chk("rerun E0", {PULSE, BUSY, DONE, LED}, 5'b00100);
    cyc(1);
    chk("rerun E1", {PULSE, BUSY, DONE, LED}, 5'b01100);
    cyc(3);
    chk("rerun E4", {PULSE, BUSY, DONE, LED}, 5'b11100);
    EN = 1'b0; cyc(1);
    chk("rerun abort", {PULSE, BUSY, DONE, LED}, 5'b00000);

    // TRIG during a run: restarts only when retriggering is enabled.
    EN = 1'b1;
    cfg(10, 0, 1, 5, 1, 2);
    TRIG = 1'b1; cyc(1); TRIG = 1'b0;
    cyc(14);
    TRIG = 1'b1; cyc(1); TRIG = 1'b0;
    chk("retrig E15", {3'b000, BUSY, DONE}, 5'b00010);
    for (int k = 16; k <= 37; k++) begin
      cyc(1);
      chk($sformatf("retrig E%0d", k), {3'b000, BUSY, DONE}, {3'b000, (k < DK), (k == DK)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
